// File: rtl/line_memory.sv
`default_nettype none
// ============================================================================
// Module   : line_memory
// Purpose  : Shared I/D backing store. It serves one 4-word line transfer at
//            a time with a fixed latency, and D has priority over I.
//            Optional per-port transfer counters: LINE_MEMORY_COUNT_EN.
// Revision : 1.0  initial release
// ============================================================================
module line_memory #(
    parameter int    MEM_WORDS = 256,
    parameter int    LATENCY   = 4,
    parameter string INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_readM,
    input  logic [15:0] i_addressM,
    output logic [63:0] i_dataM,
    output logic        i_ackM,
    input  logic        d_readM,
    input  logic        d_writeM,
    input  logic [15:0] d_addressM,
    input  logic [63:0] d_wdataM,
    output logic [63:0] d_dataM,
    output logic        d_ackM
`ifdef LINE_MEMORY_COUNT_EN
    ,
    output logic [15:0] i_accessCnt,
    output logic [15:0] d_accessCnt
`endif
);

    localparam int         AW       = $clog2(MEM_WORDS);
    localparam logic [3:0] C_LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_BUSY_I = 3'd1,
        S_BUSY_D = 3'd2,
        S_DONE_I = 3'd3,
        S_DONE_D = 3'd4
    } state_t;

    state_t      r_state, w_stateNext;
    logic [3:0]  r_cnt, w_cntNext;
    logic        r_isWrite, w_isWriteNext;
    logic [15:0] r_mem [MEM_WORDS];
    logic [63:0] r_iData, r_dData;
    logic [15:0] w_addr;
    logic [AW-1:0] w_base;
    logic [63:0] w_line;
    logic        w_enterDoneI, w_enterDoneD;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_isWrite <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_cnt     <= w_cntNext;
            r_isWrite <= w_isWriteNext;
        end
    end

    // A dropped request while BUSY aborts before the latency check can complete.
    always_comb begin
        w_stateNext   = r_state;
        w_cntNext     = r_cnt;
        w_isWriteNext = r_isWrite;
        case (r_state)
            S_IDLE: begin
                if (d_readM || d_writeM) begin
                    w_stateNext   = S_BUSY_D;
                    w_cntNext     = C_LAT_M1;
                    w_isWriteNext = d_writeM;
                end else if (i_readM) begin
                    w_stateNext   = S_BUSY_I;
                    w_cntNext     = C_LAT_M1;
                    w_isWriteNext = 1'b0;
                end
            end
            S_BUSY_I: begin
                if (!i_readM)            w_stateNext = S_IDLE;
                else if (r_cnt == 4'd0)  w_stateNext = S_DONE_I;
                else                     w_cntNext   = r_cnt - 4'd1;
            end
            S_BUSY_D: begin
                if (!(d_readM || d_writeM)) w_stateNext = S_IDLE;
                else if (r_cnt == 4'd0)     w_stateNext = S_DONE_D;
                else                        w_cntNext   = r_cnt - 4'd1;
            end
            S_DONE_I, S_DONE_D: w_stateNext = S_IDLE;
            default:            w_stateNext = S_IDLE;
        endcase
    end

    assign w_enterDoneI = (r_state == S_BUSY_I) && (w_stateNext == S_DONE_I);
    assign w_enterDoneD = (r_state == S_BUSY_D) && (w_stateNext == S_DONE_D);

    // Upper address bits beyond the array depth wrap silently.
    assign w_addr = (r_state == S_BUSY_I) ? i_addressM : d_addressM;
    assign w_base = w_addr[AW-1:0] & ~AW'(3);

    always_comb begin
        w_line = '0;
        for (int k = 0; k < 4; k++) begin
            w_line[16*k +: 16] = r_mem[w_base | AW'(k)];
        end
    end

    always_ff @(posedge clk) begin
        if (w_enterDoneD && r_isWrite) begin
            for (int k = 0; k < 4; k++) begin
                r_mem[w_base | AW'(k)] <= d_wdataM[16*k +: 16];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_iData <= 64'd0;
            r_dData <= 64'd0;
        end else begin
            if (w_enterDoneI)                r_iData <= w_line;
            if (w_enterDoneD && !r_isWrite) r_dData <= w_line;
        end
    end

    assign i_dataM = r_iData;
    assign d_dataM = r_dData;
    assign i_ackM  = (r_state == S_DONE_I);
    assign d_ackM  = (r_state == S_DONE_D);

`ifdef LINE_MEMORY_COUNT_EN
    logic [15:0] r_iCnt, r_dCnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_iCnt <= 16'd0;
            r_dCnt <= 16'd0;
        end else begin
            if (w_enterDoneI) r_iCnt <= r_iCnt + 16'd1;
            if (w_enterDoneD) r_dCnt <= r_dCnt + 16'd1;
        end
    end

    assign i_accessCnt = r_iCnt;
    assign d_accessCnt = r_dCnt;
`endif

endmodule
`default_nettype wire
